// File: rtl/full_adder_hf.sv
// Registered WIDTH-bit ripple-carry adder assembled from half-adder cells.
// Each slice is two half adders plus an OR; the result is captured every rising clk.

module full_adder_hf_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);

  assign s  = x ^ y;
  assign co = x & y;

endmodule

module full_adder_hf #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0]   cin_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g1_s;
  logic [WIDTH-1:0] g2_s;
  logic [WIDTH-1:0] s_s;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_d;
  logic             carry_out_q;

  assign cin_s[0] = c;

  // Plain ripple: each slice's carry-out feeds the next slice's carry-in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    full_adder_hf_ha u_ha1 (
      .x  (a[i]),
      .y  (b[i]),
      .s  (p_s[i]),
      .co (g1_s[i])
    );

    full_adder_hf_ha u_ha2 (
      .x  (p_s[i]),
      .y  (cin_s[i]),
      .s  (s_s[i]),
      .co (g2_s[i])
    );

    assign cin_s[i+1] = g1_s[i] | g2_s[i];
  end

  // Next-state values for the output registers
  always_comb begin
    sum_d       = s_s;
    carry_out_d = cin_s[WIDTH];
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= {WIDTH{1'b0}};
      carry_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_full_adder_hf.sv
// Self-checking bench for full_adder_hf at WIDTH 1, 4 and 8 against an arithmetic reference.
module tb_full_adder_hf;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, c1;
  logic       sum1, co1;
  logic [3:0] a4, b4, sum4;
  logic       c4, co4;
  logic [7:0] a8, b8, sum8;
  logic       c8, co8;

  int vectors;
  int miscompares;

  full_adder_hf #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .sum(sum1), .carry_out(co1)
  );
  full_adder_hf #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .sum(sum4), .carry_out(co4)
  );
  full_adder_hf #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .sum(sum8), .carry_out(co8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth table rows indexed by {a,b,c}; each entry is {sum,carry_out}.
  logic [1:0] tt [8];
  logic [1:0] bb_in  [4];
  logic [1:0] bb_out [4];
  logic [2:0] bb_abc [4];
  logic [8:0] exp8;
  logic [4:0] exp4;

  initial begin
    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    bb_abc = '{3'b001, 3'b110, 3'b111, 3'b000};
    vectors = 0;
    miscompares = 0;

    // Reset held with all-ones inputs on the 1-bit adder
    rst_n = 1'b0;
    {a1, b1, c1} = 3'b111;
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    #2;
    check("reset_w1_early", {63'd0, sum1, co1}, 65'd0);
    repeat (3) begin
      tick();
      check("reset_w1_held", {63'd0, sum1, co1}, 65'd0);
      check("reset_w4_held", {60'd0, co4, sum4}, 65'd0);
    end
    rst_n = 1'b1;
    #2;
    check("reset_release_no_edge", {63'd0, sum1, co1}, 65'd0);
    tick();
    check("reset_first_edge_w1", {63'd0, sum1, co1}, {63'd0, 2'b11});
    check("ripple_F_0_1", {60'd0, co4, sum4}, {60'd0, 1'b1, 4'h0});

    // Exhaustive WIDTH=1, each combination held for several clocks
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      logic [1:0] prev;
      prev = {sum1, co1};
      abc = i[2:0];
      {a1, b1, c1} = abc;
      #2;
      check("exh_hold_before_edge", {63'd0, sum1, co1}, {63'd0, prev});
      for (int k = 0; k < 3; k++) begin
        tick();
        check("exh_truth_table", {63'd0, sum1, co1}, {63'd0, tt[i]});
      end
    end

    // Back-to-back changes every clock
    for (int i = 0; i < 4; i++) begin
      {a1, b1, c1} = bb_abc[i];
      tick();
      check("b2b_w1", {63'd0, sum1, co1}, {63'd0, tt[bb_abc[i]]});
    end

    // Asynchronous reset between edges with outputs at 11
    {a1, b1, c1} = 3'b111;
    tick();
    check("async_pre", {63'd0, sum1, co1}, {63'd0, 2'b11});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_w1", {63'd0, sum1, co1}, 65'd0);
    check("async_clear_w4", {60'd0, co4, sum4}, 65'd0);
    #1;
    rst_n = 1'b1;
    {a1, b1, c1} = 3'b011;
    tick();
    check("async_resume", {63'd0, sum1, co1}, {63'd0, 2'b01});

    // WIDTH=4 ripple cases, then a few random ones
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    check("ripple_F_0_1_again", {60'd0, co4, sum4}, {60'd0, 1'b1, 4'h0});
    a4 = 4'hA; b4 = 4'h5; c4 = 1'b0;
    tick();
    check("ripple_A_5_0", {60'd0, co4, sum4}, {60'd0, 1'b0, 4'hF});
    for (int i = 0; i < 40; i++) begin
      a4 = 4'($urandom_range(15, 0));
      b4 = 4'($urandom_range(15, 0));
      c4 = 1'($urandom_range(1, 0));
      exp4 = 5'(a4) + 5'(b4) + 5'(c4);
      tick();
      check("rand_w4", {60'd0, co4, sum4}, {60'd0, exp4});
    end

    // Random WIDTH=8, one new vector per clock
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      exp8 = 9'(a8) + 9'(b8) + 9'(c8);
      tick();
      check("rand_w8", {56'd0, co8, sum8}, {56'd0, exp8});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
